msdap_frame_rx: RTL and testbench
=================================

# msdap_frame_rx

Parametrised multi-channel serial frame receiver for the MSDAP input path. It samples NCH frame-aligned serial audio channels, MSB first, on Dclk and reassembles each WIDTH-bit word. Completed multi-channel words go into a DEPTH-entry show-ahead FIFO that the filter core drains. It generalises the fixed 2-channel/16-bit input stage and adds buffering, overflow and framing-error reporting, and zero-run sleep detection.

## Interface
- NCH, 2, number of serial channels (channel 0 = left, 1 = right)
- WIDTH, 16, bits per sample word
- DEPTH, 4, FIFO entries; must be 2 or more
- ZERO_RUN, 800, consecutive all-zero frames before sleep asserts
- Dclk  in  1  sole clock; all sampling on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Frame  in  1  high on the cycle carrying the MSB of every channel
- Din  in  NCH  serial data; bit c = channel c
- InReady  out  1  registered; high while FIFO count < DEPTH
- rd_en  in  1  pop head entry; ignored when empty
- rd_data  out  NCH*WIDTH  head entry; channel c at [c*WIDTH +: WIDTH]
- empty  out  1  FIFO empty
- count  out  $clog2(DEPTH+1)  FIFO occupancy
- overflow  out  1  sticky; a completed word was dropped because the FIFO was full
- frame_err  out  1  one-cycle pulse; Frame seen mid-word
- sleep  out  1  zero-run sleep state

## Operation
- Reset (async, Reset_n=0) clears the shift registers, bit counter, FIFO pointers, zero-run counter and all flags.
- Reset values: InReady=0, empty=1, count=0, rd_data=0, overflow=0, frame_err=0, sleep=0.
- A reset in mid-word discards the partial word.
- Receiver states: IDLE and SHIFT.
  - IDLE: Din is ignored while Frame=0.
  - IDLE, Frame=1: the current Din bits load as MSBs, bitcnt=1, go to SHIFT.
  - SHIFT: each cycle shifts Din into every channel's register and increments bitcnt.
  - SHIFT, bitcnt=WIDTH-1: on that edge the LSB is captured, the word completes, and the state returns to IDLE.
  - SHIFT, Frame=1 when bitcnt is not 0: frame_err pulses on the next cycle. The partial word is discarded and this bit becomes the MSB of a new word (bitcnt=1, stay in SHIFT).
  - Back-to-back frames (Frame=1 on the cycle right after the LSB) are legal and do not set frame_err.
- Word completion:
  - If sleep=1 and all channels are zero: the word is dropped and the zero-run counter stays saturated.
  - Otherwise, if an all-zero word: the zero-run counter increments, saturating at ZERO_RUN. When it reaches ZERO_RUN, sleep=1 from the next cycle. The word that reaches ZERO_RUN is still pushed; later zero words are dropped.
  - Any nonzero word clears the counter and sleep in the same edge and is pushed.
  - Push when the FIFO is full and there is no same-cycle pop: the word is dropped and overflow=1 until reset.
- FIFO is show-ahead:
  - rd_data is always the oldest entry; it is 0 when empty.
  - rd_en with empty=0 pops on the rising edge.
  - Simultaneous push and pop is legal at any occupancy, including full: count is unchanged and nothing is dropped.
  - Pointers wrap modulo DEPTH; DEPTH need not be a power of 2.

## Timing
- Latency: LSB sampled at edge k → entry visible (empty=0, count+1, rd_data valid if it was the only entry) after edge k.
- Pop at edge k → next entry on rd_data after edge k.
- InReady is registered from next-state count: it is 1 after the first edge following reset release. It drops after the edge where count becomes DEPTH and rises after the edge where count falls below DEPTH.
- frame_err: high for exactly one cycle, the cycle after the offending Frame sample.
- overflow and sleep update on the LSB edge and are visible after it.
- Max throughput: one word per WIDTH cycles. With no pops, DEPTH words fit before overflow.

## Test plan
- Reset then 2 frames, L=16'hA5C3 and R=16'h0F0F, then 16'h1234 and 16'h8001, with no rd_en. Required: count=2 and rd_data=32'h0F0F_A5C3. One pop gives rd_data=32'h8001_1234; a second pop gives empty=1.
- Send DEPTH+1=5 nonzero frames without reading. Required: InReady=0 after the 4th LSB edge, overflow=1 after the 5th, and the FIFO holds the first 4 words. Then send frame 6 with a pop on its LSB edge: count stays 4 and overflow stays 1.
- Assert Frame again at bit 7 of a word. Required: frame_err=1 for one cycle, the partial word is never pushed, and the new word starting at that bit is received correctly.
- ZERO_RUN=4: send 6 all-zero frames, then 16'h0001 on the left channel. Required: 4 zero entries in the FIFO and sleep=1 after the 4th. Frames 5–6 are dropped; the nonzero frame is pushed and clears sleep.
- Pulse Reset_n low at bit 9 of a word with 2 entries queued. Required: all outputs at reset values immediately. After release, InReady=1 after one edge and the next full frame is received as the only entry.
- Parameter sweep NCH=4, WIDTH=24, DEPTH=3 with channel c value = 24'hC00000+c. Required: rd_data packs channels at [c*24 +: 24] and pointer wrap is correct over 10 frames with continuous pops.

Source files
------------

// File: rtl/msdap_frame_rx.sv
// msdap_frame_rx
// Multi-channel serial frame receiver for the MSDAP input path. NCH
// frame-aligned serial channels are sampled MSB first on Dclk and each
// WIDTH-bit word is rebuilt. Completed multi-channel words are queued in a
// DEPTH-entry show-ahead FIFO for the filter core. Long runs of all-zero
// frames put the receiver to sleep; further zero frames are then dropped.
//
// Ports
//   Dclk      in   sole clock, rising edge
//   Reset_n   in   asynchronous active-low reset
//   Frame     in   high on the cycle carrying every channel's MSB
//   Din       in   serial data, bit c = channel c (0 = left, 1 = right)
//   InReady   out  registered, high while FIFO occupancy < DEPTH
//   rd_en     in   pop the head entry (ignored when empty)
//   rd_data   out  head entry, channel c at [c*WIDTH +: WIDTH]; 0 when empty
//   empty     out  FIFO empty
//   count     out  FIFO occupancy
//   overflow  out  sticky, a completed word was dropped on a full FIFO
//   frame_err out  one-cycle pulse, Frame seen in the middle of a word
//   sleep     out  zero-run sleep state
module msdap_frame_rx #(
    parameter int NCH      = 2,
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 4,
    parameter int ZERO_RUN = 800
) (
    input  logic                       Dclk,
    input  logic                       Reset_n,
    input  logic                       Frame,
    input  logic [NCH-1:0]             Din,
    output logic                       InReady,
    input  logic                       rd_en,
    output logic [NCH*WIDTH-1:0]       rd_data,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       frame_err,
    output logic                       sleep
);
    localparam int BW = $clog2(WIDTH);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int ZW = $clog2(ZERO_RUN + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [ZW-1:0] ZR_MAX   = ZW'(ZERO_RUN);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                    state, stateNext;
    logic [BW-1:0]             bitCnt, bitCntNext;
    logic [NCH-1:0][WIDTH-1:0] shReg, shRegNext, word;
    logic                      wordDone, ferrNext;

    logic [NCH*WIDTH-1:0]      mem [DEPTH];
    logic [PW-1:0]             wrPtr, rdPtr;
    logic [CW-1:0]             cnt, cntNext;
    logic [ZW-1:0]             zCnt;
    logic                      allZero, pushReq, pushOk, pop;

    // Saturating increment of the zero-run counter.
    function automatic logic [ZW-1:0] satInc(input logic [ZW-1:0] v);
        return (v >= ZR_MAX) ? ZR_MAX : v + 1'b1;
    endfunction

    // Pointer advance modulo DEPTH (DEPTH need not be a power of two).
    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // ---- Deserialiser: next-state and shift logic ----
    always_comb begin
        stateNext  = state;
        bitCntNext = bitCnt;
        shRegNext  = shReg;
        wordDone   = 1'b0;
        ferrNext   = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            word[c] = {shReg[c][WIDTH-2:0], Din[c]};
        end
        case (state)
            IDLE: begin
                if (Frame) begin
                    for (int c = 0; c < NCH; c++) shRegNext[c] = WIDTH'(Din[c]);
                    bitCntNext = BW'(1);
                    stateNext  = SHIFT;
                end
            end
            SHIFT: begin
                if (Frame) begin
                    // Misplaced frame marker: drop the partial word and
                    // treat this bit as the MSB of a fresh word.
                    ferrNext = 1'b1;
                    for (int c = 0; c < NCH; c++) shRegNext[c] = WIDTH'(Din[c]);
                    bitCntNext = BW'(1);
                end else begin
                    shRegNext = word;
                    if (bitCnt == LAST_BIT) begin
                        wordDone   = 1'b1;
                        bitCntNext = '0;
                        stateNext  = IDLE;
                    end else begin
                        bitCntNext = bitCnt + 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge Dclk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            bitCnt    <= '0;
            shReg     <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= stateNext;
            bitCnt    <= bitCntNext;
            shReg     <= shRegNext;
            frame_err <= ferrNext;
        end
    end

    // ---- Word completion: zero-run tracking and FIFO push/pop ----
    assign allZero = (word == '0);
    // Zero words are discarded entirely once asleep.
    assign pushReq = wordDone && !(sleep && allZero);
    assign pop     = rd_en && !empty;
    // A full FIFO still accepts a word when the head leaves on the same edge.
    assign pushOk  = pushReq && ((cnt != FULL_CNT) || pop);

    always_comb begin
        cntNext = cnt;
        if (pushOk && !pop)      cntNext = cnt + 1'b1;
        else if (!pushOk && pop) cntNext = cnt - 1'b1;
    end

    always_ff @(posedge Dclk or negedge Reset_n) begin
        if (!Reset_n) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            cnt      <= '0;
            InReady  <= 1'b0;
            overflow <= 1'b0;
            zCnt     <= '0;
            sleep    <= 1'b0;
        end else begin
            if (pushOk) wrPtr <= nextPtr(wrPtr);
            if (pop)    rdPtr <= nextPtr(rdPtr);
            cnt     <= cntNext;
            InReady <= (cntNext < FULL_CNT);
            if (pushReq && !pushOk) overflow <= 1'b1;
            if (wordDone) begin
                if (!allZero) begin
                    zCnt  <= '0;
                    sleep <= 1'b0;
                end else if (!sleep) begin
                    zCnt <= satInc(zCnt);
                    if (satInc(zCnt) == ZR_MAX) sleep <= 1'b1;
                end
            end
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge Dclk) begin
        if (pushOk) mem[wrPtr] <= word;
    end

    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign rd_data = empty ? '0 : mem[rdPtr];
endmodule

// File: tb/tb_msdap_frame_rx.sv
module tb_msdap_frame_rx;
    logic        Dclk = 1'b0;
    logic        Reset_n = 1'b1;
    // Instance A: 2 channels x 16 bits, 4 entries, sleep after 4 zero frames
    logic        Frame = 1'b0;
    logic [1:0]  Din = '0;
    logic        rd_en = 1'b0;
    logic        InReady, empty, overflow, frame_err, sleep;
    logic [31:0] rd_data;
    logic [2:0]  count;
    // Instance B: 4 channels x 24 bits, 3 entries
    logic        FrameB = 1'b0;
    logic [3:0]  DinB = '0;
    logic        rdEnB = 1'b0;
    logic        InReadyB, emptyB, overflowB, frameErrB, sleepB;
    logic [95:0] rdDataB;
    logic [1:0]  countB;

    int checks = 0;
    int failures = 0;

    // Reference models: plain queues plus flags
    logic [31:0] mq[$];
    bit          mOvf, mSleep;
    int          mZrun;
    logic [95:0] mqB[$];
    bit          mOvfB;

    always #5 Dclk = ~Dclk;

    msdap_frame_rx #(.NCH(2), .WIDTH(16), .DEPTH(4), .ZERO_RUN(4)) dutA (
        .Dclk(Dclk), .Reset_n(Reset_n), .Frame(Frame), .Din(Din),
        .InReady(InReady), .rd_en(rd_en), .rd_data(rd_data), .empty(empty),
        .count(count), .overflow(overflow), .frame_err(frame_err), .sleep(sleep)
    );

    msdap_frame_rx #(.NCH(4), .WIDTH(24), .DEPTH(3)) dutB (
        .Dclk(Dclk), .Reset_n(Reset_n), .Frame(FrameB), .Din(DinB),
        .InReady(InReadyB), .rd_en(rdEnB), .rd_data(rdDataB), .empty(emptyB),
        .count(countB), .overflow(overflowB), .frame_err(frameErrB), .sleep(sleepB)
    );

    task automatic chk(input string tag, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Word-level behaviour of instance A on a completed word
    task automatic modelWordA(input logic [31:0] w, input bit popped);
        bit push = 1;
        if (popped && mq.size() > 0) void'(mq.pop_front());
        if (w == 0) begin
            if (mSleep) push = 0;
            else begin
                mZrun++;
                if (mZrun == 4) mSleep = 1;
            end
        end else begin
            mZrun = 0;
            mSleep = 0;
        end
        if (push) begin
            if (mq.size() < 4) mq.push_back(w);
            else mOvf = 1;
        end
    endtask

    task automatic checkA(input string tag);
        chk({tag, "/count"}, count, mq.size());
        chk({tag, "/empty"}, empty, mq.size() == 0);
        chk({tag, "/rd_data"}, rd_data, (mq.size() > 0) ? mq[0] : 32'h0);
        chk({tag, "/InReady"}, InReady, mq.size() < 4);
        chk({tag, "/overflow"}, overflow, mOvf);
        chk({tag, "/sleep"}, sleep, mSleep);
    endtask

    task automatic checkB(input string tag);
        chk({tag, "/countB"}, countB, mqB.size());
        chk({tag, "/emptyB"}, emptyB, mqB.size() == 0);
        chk({tag, "/rdDataB"}, rdDataB, (mqB.size() > 0) ? mqB[0] : 96'h0);
        chk({tag, "/InReadyB"}, InReadyB, mqB.size() < 3);
        chk({tag, "/overflowB"}, overflowB, mOvfB);
        chk({tag, "/ferrB"}, frameErrB, 1'b0);
        chk({tag, "/sleepB"}, sleepB, 1'b0);
    endtask

    task automatic driveBitA(input bit fr, input logic [1:0] d, input bit rd);
        Frame = fr;
        Din   = d;
        rd_en = rd;
        @(posedge Dclk);
        #1;
        Frame = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic sendA(input logic [31:0] w, input bit popLsb, input bit errFirst);
        for (int i = 0; i < 16; i++) begin
            driveBitA(i == 0, {w[31-i], w[15-i]}, popLsb && (i == 15));
            chk("frame_err", frame_err, (i == 0) ? errFirst : 1'b0);
        end
        modelWordA(w, popLsb);
    endtask

    task automatic popA();
        driveBitA(1'b0, 2'($urandom), 1'b1);
        if (mq.size() > 0) void'(mq.pop_front());
    endtask

    task automatic sendB(input logic [95:0] w, input bit popLsb);
        for (int i = 0; i < 24; i++) begin
            FrameB = (i == 0);
            for (int c = 0; c < 4; c++) DinB[c] = w[c*24 + 23 - i];
            rdEnB = popLsb && (i == 23);
            @(posedge Dclk);
            #1;
            FrameB = 1'b0;
            rdEnB  = 1'b0;
        end
        if (popLsb && mqB.size() > 0) void'(mqB.pop_front());
        if (mqB.size() < 3) mqB.push_back(w);
        else mOvfB = 1;
    endtask

    task automatic applyReset();
        Reset_n = 1'b0;
        Frame = 1'b0; rd_en = 1'b0; FrameB = 1'b0; rdEnB = 1'b0;
        #1;
        chk("rst/InReady", InReady, 1'b0);
        chk("rst/empty", empty, 1'b1);
        chk("rst/count", count, 0);
        chk("rst/rd_data", rd_data, 0);
        chk("rst/overflow", overflow, 1'b0);
        chk("rst/frame_err", frame_err, 1'b0);
        chk("rst/sleep", sleep, 1'b0);
        chk("rst/countB", countB, 0);
        mq.delete(); mOvf = 0; mSleep = 0; mZrun = 0;
        mqB.delete(); mOvfB = 0;
        @(posedge Dclk);
        #1;
        Reset_n = 1'b1;
        @(posedge Dclk);
        #1;
        chk("rst/InReady_release", InReady, 1'b1);
    endtask

    initial begin
        logic [31:0] w;
        logic [95:0] wb;
        #3;
        applyReset();

        // Two back-to-back frames, then two pops
        sendA(32'h0F0F_A5C3, 0, 0);
        sendA(32'h8001_1234, 0, 0);
        chk("t1/count", count, 2);
        chk("t1/rd_data", rd_data, 32'h0F0F_A5C3);
        checkA("t1");
        popA();
        chk("t1/pop1", rd_data, 32'h8001_1234);
        popA();
        chk("t1/pop2_empty", empty, 1'b1);
        checkA("t1b");

        // Frame re-asserted at bit 7: partial word discarded
        for (int i = 0; i < 7; i++) begin
            driveBitA(i == 0, 2'($urandom), 1'b0);
            chk("ferr_quiet", frame_err, 1'b0);
        end
        sendA(32'hBEEF_1357, 0, 1);
        chk("ferr/rd_data", rd_data, 32'hBEEF_1357);
        checkA("ferr");
        popA();

        // Overflow: DEPTH+1 frames, then a sixth frame with pop on its LSB
        for (int k = 0; k < 5; k++) begin
            w = $urandom | 32'h1;
            sendA(w, 0, 0);
            if (k == 2) chk("ovf/InReady3", InReady, 1'b1);
            if (k == 3) chk("ovf/InReady4", InReady, 1'b0);
            if (k == 4) chk("ovf/overflow5", overflow, 1'b1);
            checkA("ovf");
        end
        sendA($urandom | 32'h2, 1, 0);
        chk("ovf/count6", count, 4);
        chk("ovf/overflow6", overflow, 1'b1);
        checkA("ovf6");
        for (int k = 0; k < 4; k++) begin
            popA();
            checkA("ovf_drain");
        end

        // Reset at bit 9 of a word with two entries queued
        sendA(32'h1111_2222, 0, 0);
        sendA(32'h3333_4444, 0, 0);
        checkA("pre_rst");
        for (int i = 0; i < 9; i++) driveBitA(i == 0, 2'b11, 1'b0);
        applyReset();
        sendA(32'h5A5A_C3C3, 0, 0);
        chk("post_rst/count", count, 1);
        chk("post_rst/rd_data", rd_data, 32'h5A5A_C3C3);
        checkA("post_rst");
        popA();

        // Zero-run sleep
        for (int k = 0; k < 6; k++) begin
            sendA(32'h0, 0, 0);
            if (k == 3) begin
                chk("zr/sleep4", sleep, 1'b1);
                chk("zr/count4", count, 4);
            end
            checkA("zr");
        end
        chk("zr/count6", count, 4);
        chk("zr/no_ovf", overflow, 1'b0);
        for (int k = 0; k < 4; k++) popA();
        sendA(32'h0000_0001, 0, 0);
        chk("zr/wake_sleep", sleep, 1'b0);
        chk("zr/wake_data", rd_data, 32'h0000_0001);
        checkA("zr_wake");
        popA();

        // Randomized traffic against the model
        for (int k = 0; k < 40; k++) begin
            w = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            sendA(w, bit'($urandom_range(0, 1)), 0);
            checkA("rand");
            if ($urandom_range(0, 2) == 0) begin
                popA();
                checkA("rand_pop");
            end
            for (int g = 0; g < int'($urandom_range(0, 2)); g++)
                driveBitA(1'b0, 2'($urandom), 1'b0);
        end

        // Instance B: fill, then simultaneous push/pop at full, then drain
        for (int f = 0; f < 13; f++) begin
            for (int c = 0; c < 4; c++) wb[c*24 +: 24] = 24'hC00000 + 24'(c) + 24'(f << 8);
            sendB(wb, f >= 3);
            checkB("b");
        end
        chk("b/full_count", countB, 3);
        for (int k = 0; k < 3; k++) begin
            rdEnB = 1'b1;
            @(posedge Dclk);
            #1;
            rdEnB = 1'b0;
            void'(mqB.pop_front());
            checkB("b_drain");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
